// File: rtl/node_readout.sv
// Node readout sequencer: on START, waits for a forward-pass frame and then sweeps every
// decoder node index. Each node value is strobed, captured, and handed over a valid/ready port.
module node_readout #(
  parameter int N_NODES = 38,
  parameter int DW      = 16
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          START,
  input  logic          FP_FRAME,
  input  logic [DW-1:0] NodeOutputExp_data,
  output logic          NodeOutputExp_clk,
  output logic [DW-1:0] NodeOutputExp_index,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          overrun,
  output logic [2:0]    dbg_state
);

  // Output handshake: a word transfers on any rising CLK edge where out_valid and out_ready
  // are both high. Once out_valid is raised, out_data and out_last hold until that transfer.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_SETIDX  = 3'd2,
    S_STROBE  = 3'd3,
    S_CAPTURE = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam logic [DW-1:0] LAST_IDX = DW'(N_NODES - 1);

  state_t        state_q;
  logic [DW-1:0] idx_q;
  logic [DW-1:0] idx_d;
  logic          nclk_q;
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          last_q;
  logic          overrun_q;
  logic          at_last;
  logic          xfer;

  assign at_last = (idx_q == LAST_IDX);
  assign xfer    = valid_q && out_ready;

  // Next index wraps to zero after the final node, so no index >= N_NODES is ever driven.
  always_comb begin
    idx_d = idx_q;
    if (at_last) begin
      idx_d = '0;
    end else begin
      idx_d = idx_q + DW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      nclk_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A frame pulse that coincides with START is not taken as the arming frame.
          if (START) begin
            state_q   <= S_ARM;
            overrun_q <= 1'b0;
          end
        end
        S_ARM: begin
          if (FP_FRAME) begin
            state_q <= S_SETIDX;
            idx_q   <= '0;
          end
        end
        S_SETIDX: begin
          if (FP_FRAME) overrun_q <= 1'b1;
          nclk_q  <= 1'b1;
          state_q <= S_STROBE;
        end
        S_STROBE: begin
          if (FP_FRAME) overrun_q <= 1'b1;
          nclk_q  <= 1'b0;
          data_q  <= NodeOutputExp_data;
          valid_q <= 1'b1;
          last_q  <= at_last;
          state_q <= S_CAPTURE;
        end
        S_CAPTURE, S_HOLD: begin
          if (FP_FRAME) overrun_q <= 1'b1;
          if (xfer) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= idx_d;
            state_q <= at_last ? S_IDLE : S_SETIDX;
          end else begin
            state_q <= S_HOLD;
          end
        end
        default: begin
          state_q <= S_IDLE;
          idx_q   <= '0;
          nclk_q  <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign NodeOutputExp_clk   = nclk_q;
  assign NodeOutputExp_index = idx_q;
  assign out_data            = data_q;
  assign out_valid           = valid_q;
  assign out_last            = last_q;
  assign busy                = (state_q != S_IDLE);
  assign overrun             = overrun_q;
  assign dbg_state           = state_q;

`ifndef SYNTHESIS
  a_strobe_one_cycle: assert property (@(posedge CLK) disable iff (!RESET_N)
    nclk_q |=> !nclk_q);
  a_index_in_range: assert property (@(posedge CLK) disable iff (!RESET_N)
    idx_q < LAST_IDX + DW'(1));
  a_hold_stable: assert property (@(posedge CLK) disable iff (!RESET_N)
    (valid_q && !out_ready) |=> (valid_q && $stable(data_q) && $stable(last_q)));
`endif

endmodule

// File: tb/tb_node_readout.sv
// Directed bench for node_readout: decoder model returns 0x1000+index while strobed,
// and each sweep's words are scored against an expected queue.
module tb_node_readout;

  localparam int N  = 38;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          fp_frame;
  logic [DW-1:0] dec_data;
  logic          dec_clk;
  logic [DW-1:0] dec_index;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          overrun;
  logic [2:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];
  int words     = 0;
  int last_cnt  = 0;
  int strb_cnt  = 0;
  int wide_err  = 0;
  logic prev_strb = 1'b0;

  node_readout #(.N_NODES(N), .DW(DW)) dut (
    .CLK                 (clk),
    .RESET_N             (rst_n),
    .START               (start),
    .FP_FRAME            (fp_frame),
    .NodeOutputExp_data  (dec_data),
    .NodeOutputExp_clk   (dec_clk),
    .NodeOutputExp_index (dec_index),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_last            (out_last),
    .busy                (busy),
    .overrun             (overrun),
    .dbg_state           (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder bank model: value is only meaningful while the strobe is high.
  assign dec_data = dec_clk ? (16'h1000 + dec_index) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted word is compared with the head of exp_q.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dec_clk) begin
        strb_cnt++;
        if (prev_strb) wide_err++;
      end
      prev_strb = dec_clk;
      if (out_valid && out_ready) begin
        words++;
        if (out_last) last_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", {16'h0, out_data}, 32'hFFFF_FFFF);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          check("word_data", {16'h0, out_data}, {16'h0, e});
          check("word_last", {31'h0, out_last}, {31'h0, (e == 16'h1000 + N - 1)});
        end
      end
    end else begin
      prev_strb = 1'b0;
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    words    = 0;
    last_cnt = 0;
    strb_cnt = 0;
    wide_err = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(16'h1000 + 16'(i));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_fp();
    fp_frame = 1'b1;
    step(1);
    fp_frame = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      cnt++;
      if (!busy) return;
    end
    check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_strobe_at(input int idx);
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (dec_clk && dec_index == 16'(idx)) return;
    end
    check("wait_strobe_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_sweep_done(input string tag);
    check({tag, "_words"}, words, N);
    check({tag, "_exp_empty"}, exp_q.size(), 0);
    check({tag, "_last_cnt"}, last_cnt, 1);
    check({tag, "_strobes"}, strb_cnt, N);
    check({tag, "_strobe_width"}, wide_err, 0);
    check({tag, "_busy_low"}, {31'h0, busy}, 0);
    check({tag, "_valid_low"}, {31'h0, out_valid}, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, {16'h0, out_data}, 0);
    check({tag, "_valid"}, {31'h0, out_valid}, 0);
    check({tag, "_last"}, {31'h0, out_last}, 0);
    check({tag, "_dclk"}, {31'h0, dec_clk}, 0);
    check({tag, "_index"}, {16'h0, dec_index}, 0);
    check({tag, "_busy"}, {31'h0, busy}, 0);
    check({tag, "_overrun"}, {31'h0, overrun}, 0);
  endtask

  initial begin
    int cyc;
    int bad;
    rst_n     = 1'b0;
    start     = 1'b0;
    fp_frame  = 1'b0;
    out_ready = 1'b1;
    step(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    step(2);
    check("idle_after_reset", {31'h0, busy}, 0);

    // Full sweep, ready high: 114 cycles after the ARM exit edge
    clear_counts();
    pulse_start();
    check("arm_state", {29'h0, dbg_state}, 1);
    pulse_fp();
    wait_idle(cyc);
    check("sweep_cycles", cyc, 3 * N);
    check_sweep_done("basic");

    // Backpressure at index 5
    clear_counts();
    pulse_start();
    pulse_fp();
    wait_strobe_at(5);
    out_ready = 1'b0;
    step(1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (!out_valid || out_data != 16'h1005 || out_last || dec_index != 16'd5 || dec_clk) bad++;
    end
    check("hold_stable", bad, 0);
    check("hold_data", {16'h0, out_data}, 32'h1005);
    check("hold_words_so_far", words, 5);
    out_ready = 1'b1;
    wait_idle(cyc);
    check_sweep_done("backpressure");

    // Frame pulse mid-sweep sets sticky overrun
    clear_counts();
    pulse_start();
    check("overrun_clear_pre", {31'h0, overrun}, 0);
    pulse_fp();
    wait_strobe_at(20);
    pulse_fp();
    check("overrun_set", {31'h0, overrun}, 1);
    wait_idle(cyc);
    check("overrun_sticky", {31'h0, overrun}, 1);
    check_sweep_done("overrun");
    clear_counts();
    pulse_start();
    check("overrun_cleared_by_start", {31'h0, overrun}, 0);
    pulse_fp();
    wait_idle(cyc);
    check_sweep_done("after_overrun");

    // START while busy is ignored
    clear_counts();
    pulse_start();
    pulse_fp();
    wait_strobe_at(10);
    pulse_start();
    wait_idle(cyc);
    check_sweep_done("busy_start");
    step(6);
    check("no_queued_start", {31'h0, busy}, 0);
    check("no_extra_strobes", strb_cnt, N);
    clear_counts();
    pulse_start();
    pulse_fp();
    wait_idle(cyc);
    check_sweep_done("single_after_ignore");

    // Reset while holding index 12
    clear_counts();
    pulse_start();
    pulse_fp();
    wait_strobe_at(12);
    out_ready = 1'b0;
    step(3);
    check("hold12_state", {29'h0, dbg_state}, 5);
    check("hold12_data", {16'h0, out_data}, 32'h100C);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    step(2);
    rst_n = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    strb_cnt = 0;
    words = 0;
    step(10);
    check("post_reset_idle", {31'h0, busy}, 0);
    check("post_reset_no_strobe", strb_cnt, 0);
    check("post_reset_no_words", words, 0);

    // START and FP_FRAME together: ARM waits for the next frame
    clear_counts();
    start    = 1'b1;
    fp_frame = 1'b1;
    step(1);
    start    = 1'b0;
    fp_frame = 1'b0;
    step(5);
    check("coincident_arm", {29'h0, dbg_state}, 1);
    check("coincident_no_strobe", strb_cnt, 0);
    pulse_fp();
    wait_idle(cyc);
    check("coincident_cycles", cyc, 3 * N);
    check_sweep_done("coincident");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/node_readout.md
NODE_READOUT -- requirements
Module: node_readout

Parameters
REQ-001 SHALL have parameter N_NODES, default 38: number of decoded node values swept per readout (indices 0..N_NODES-1).
REQ-002 SHALL have parameter DW, default 16: width of each node value and of the index bus.

Interface
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-005 START  input  1  single-cycle readout request.
REQ-006 FP_FRAME  input  1  forward-pass frame pulse; marks freshly latched node means.
REQ-007 NodeOutputExp_data  input  DW  node value returned by the decoder bank for the current index.
REQ-008 NodeOutputExp_clk  output  1  registered sampling strobe to the decoder bank.
REQ-009 NodeOutputExp_index  output  DW  registered node index to the decoder bank.
REQ-010 out_data  output  DW  captured node value.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_ready  input  1  consumer accepts the word when high with out_valid.
REQ-013 out_last  output  1  high with out_valid on the word for index N_NODES-1.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 overrun  output  1  sticky: FP_FRAME arrived during a sweep.

Function
REQ-016 FSM states SHALL be IDLE, ARM, SETIDX, STROBE, CAPTURE, HOLD.
REQ-017 IDLE: START=1 -> ARM, clearing overrun; otherwise stay.
REQ-018 ARM: wait for FP_FRAME=1; then -> SETIDX with index=0; sweep starts aligned to a frame boundary.
REQ-019 SETIDX: NodeOutputExp_index holds the current index, NodeOutputExp_clk=0; unconditionally -> STROBE.
REQ-020 STROBE: NodeOutputExp_clk=1 for exactly one CLK cycle; unconditionally -> CAPTURE.
REQ-021 On the STROBE->CAPTURE edge, out_data SHALL load NodeOutputExp_data.
REQ-022 CAPTURE/HOLD: NodeOutputExp_clk=0; out_valid=1; out_data and out_last stable until accepted.
REQ-023 Transfer occurs on any edge with out_valid=1 and out_ready=1; out_valid falls on the following cycle unless a new word is presented.
REQ-024 On transfer, if index<N_NODES-1: index+1 and -> SETIDX; if index=N_NODES-1: index->0 and -> IDLE.
REQ-025 CAPTURE with out_ready=0 -> HOLD; HOLD remains until transfer (unbounded backpressure, no data loss).
REQ-026 Minimum throughput: one word per 3 CLK cycles with out_ready tied high; a full sweep is 3*N_NODES cycles after the ARM exit.
REQ-027 START while busy=1 SHALL be ignored; no queuing.
REQ-028 FP_FRAME in SETIDX/STROBE/CAPTURE/HOLD SHALL set overrun; the sweep continues without restart.
REQ-029 FP_FRAME and START in the same IDLE cycle: go to ARM only; that FP_FRAME does not satisfy ARM.
REQ-030 Index arithmetic is unsigned DW-bit; no index >= N_NODES is ever driven.

Reset
REQ-031 RESET_N=0 SHALL immediately force IDLE and out_data=0, out_valid=0, out_last=0, NodeOutputExp_clk=0, NodeOutputExp_index=0, busy=0, overrun=0.
REQ-032 Reset mid-sweep discards the in-flight word; after release the block waits in IDLE for a new START.
REQ-033 Reset deassertion is synchronous to CLK by the integrating level; the block adds no synchronizer.

Verification
REQ-034 N_NODES=38, decoder model returns 0x1000+index, out_ready=1, START then FP_FRAME -> 38 words 0x1000..0x1025 in order, out_last only on 0x1025, 114 cycles, busy low afterwards.
REQ-035 out_ready held low 10 cycles at index 5 -> out_data=0x1005 and out_valid stay stable throughout; index 6 follows only after ready rises; no word lost or duplicated.
REQ-036 FP_FRAME pulsed at index 20 -> overrun=1 through the end of the sweep; all 38 words are still delivered; next START clears overrun.
REQ-037 START at index 10 -> ignored; sweep ends normally; a single START/FP_FRAME afterwards yields exactly one new sweep.
REQ-038 RESET_N low for 2 cycles in HOLD at index 12 -> all outputs 0 asynchronously; after release there is no activity without START.
REQ-039 START and FP_FRAME coincident -> block stays in ARM until the next FP_FRAME; NodeOutputExp_clk pulses exactly once per index, 1 cycle wide.
